// File: rtl/display_horas_minutos_if.sv
// -----------------------------------------------------------------------------
// display_horas_minutos_if
// Bundle between the hour/minute counters, the display driver and the
// seven-segment panel.
//   horas     [4:0]  hour count (0-23) from the hour counter
//   minutos   [5:0]  minute count (0-59) from the minute counter
//   anodos    [3:0]  digit enables, active low (bit 0 = minute units)
//   segmentos [6:0]  segments {g,f,e,d,c,b,a}, active low
//   punto            decimal point / colon, active low
// Modports:
//   master : counter/panel side (drives the counts, observes the display)
//   slave  : display driver (reads the counts, drives the display)
// -----------------------------------------------------------------------------
interface display_horas_minutos_if;
    logic [4:0] horas;
    logic [5:0] minutos;
    logic [3:0] anodos;
    logic [6:0] segmentos;
    logic       punto;

    modport master (
        output horas,
        output minutos,
        input  anodos,
        input  segmentos,
        input  punto
    );

    modport slave (
        input  horas,
        input  minutos,
        output anodos,
        output segmentos,
        output punto
    );
endinterface

// File: rtl/display_horas_minutos.sv
// -----------------------------------------------------------------------------
// display_horas_minutos
// Multiplexed four-digit common-anode seven-segment driver for HH:MM.
// The hour and minute counts are snapshotted once per scan frame (and on the
// first cycle after reset), split into decimal digits and shown one digit at
// a time. A colon dot on the hour-units digit blinks at BLINK_DIV cycles per
// half-period.
//
// Parameters:
//   SCAN_DIV  (>= 2) clock cycles each digit stays lit
//   BLINK_DIV (>= 1) clock cycles per colon half-period
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    display_horas_minutos_if.slave (horas/minutos in,
//          anodos/segmentos/punto out, all outputs registered)
// Optional feature:
//   HOUR_LEADING_BLANK_EN - when defined, an in-range hour tens digit of 0
//   is shown blank instead of "0".
// -----------------------------------------------------------------------------
module display_horas_minutos #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic                          clock,
    input  logic                          reset,
    display_horas_minutos_if.slave        bus
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segment pattern for one decimal digit, active low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Tens digit of a 0..63 value by constant comparisons.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [3:0] t;
        if (v >= 6'd60)      t = 4'd6;
        else if (v >= 6'd50) t = 4'd5;
        else if (v >= 6'd40) t = 4'd4;
        else if (v >= 6'd30) t = 4'd3;
        else if (v >= 6'd20) t = 4'd2;
        else if (v >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        return t;
    endfunction

    // Units digit: subtract the constant multiple of ten chosen by tens_of.
    function automatic logic [3:0] units_of(input logic [5:0] v, input logic [3:0] t);
        logic [5:0] u;
        case (t)
            4'd0:    u = v;
            4'd1:    u = v - 6'd10;
            4'd2:    u = v - 6'd20;
            4'd3:    u = v - 6'd30;
            4'd4:    u = v - 6'd40;
            4'd5:    u = v - 6'd50;
            4'd6:    u = v - 6'd60;
            default: u = 6'd0;
        endcase
        return u[3:0];
    endfunction

    logic            r_start;      // first cycle after reset: load snapshot only
    logic [SW-1:0]   r_scan_cnt;
    logic [1:0]      r_idx;
    logic [BW-1:0]   r_blink_cnt;
    logic            r_colon;
    logic [4:0]      r_h_snap;
    logic [5:0]      r_m_snap;
    logic [3:0]      r_anodos;
    logic [6:0]      r_segmentos;
    logic            r_punto;

    logic            w_scan_wrap;
    logic            w_frame_wrap;
    logic            w_blink_wrap;
    logic            w_h_ok;
    logic            w_m_ok;
    logic [3:0]      w_h_tens;
    logic [3:0]      w_h_units;
    logic [3:0]      w_m_tens;
    logic [3:0]      w_m_units;
    logic [3:0]      w_ano_next;
    logic [6:0]      w_seg_next;

    assign w_scan_wrap  = (r_scan_cnt == SCAN_LAST);
    assign w_frame_wrap = w_scan_wrap && (r_idx == 2'd3);
    assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);

    assign w_h_ok    = (r_h_snap <= 5'd23);
    assign w_m_ok    = (r_m_snap <= 6'd59);
    assign w_h_tens  = tens_of({1'b0, r_h_snap});
    assign w_h_units = units_of({1'b0, r_h_snap}, w_h_tens);
    assign w_m_tens  = tens_of(r_m_snap);
    assign w_m_units = units_of(r_m_snap, w_m_tens);

    // Anode and segment pattern for the digit currently selected by r_idx.
    always_comb begin
        w_ano_next = 4'b1111;
        w_seg_next = SEG_BLANK;
        case (r_idx)
            2'd0: begin
                w_ano_next = 4'b1110;
                if (w_m_ok) w_seg_next = seg7(w_m_units);
                else        w_seg_next = SEG_DASH;
            end
            2'd1: begin
                w_ano_next = 4'b1101;
                if (w_m_ok) w_seg_next = seg7(w_m_tens);
                else        w_seg_next = SEG_DASH;
            end
            2'd2: begin
                w_ano_next = 4'b1011;
                if (w_h_ok) w_seg_next = seg7(w_h_units);
                else        w_seg_next = SEG_DASH;
            end
            2'd3: begin
                w_ano_next = 4'b0111;
                if (!w_h_ok) begin
                    w_seg_next = SEG_DASH;
                end else begin
`ifdef HOUR_LEADING_BLANK_EN
                    if (w_h_tens == 4'd0) w_seg_next = SEG_BLANK;
                    else                  w_seg_next = seg7(w_h_tens);
`else
                    w_seg_next = seg7(w_h_tens);
`endif
                end
            end
            default: begin
                w_ano_next = 4'b1111;
                w_seg_next = SEG_BLANK;
            end
        endcase
    end

    // Scan/blink counters, digit index and per-frame input snapshot.
    // Counters hold during the start cycle so digit 0 gets a full SCAN_DIV.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_start     <= 1'b1;
            r_scan_cnt  <= '0;
            r_idx       <= 2'd0;
            r_blink_cnt <= '0;
            r_colon     <= 1'b0;
            r_h_snap    <= 5'd0;
            r_m_snap    <= 6'd0;
        end else if (r_start) begin
            r_start  <= 1'b0;
            r_h_snap <= bus.horas;
            r_m_snap <= bus.minutos;
        end else begin
            if (w_scan_wrap) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + {{(SW-1){1'b0}}, 1'b1};
            end
            if (w_blink_wrap) begin
                r_blink_cnt <= '0;
                r_colon     <= ~r_colon;
            end else begin
                r_blink_cnt <= r_blink_cnt + {{(BW-1){1'b0}}, 1'b1};
            end
            // New values land together with the idx 3->0 wrap, so the whole
            // next frame is drawn from one coherent snapshot.
            if (w_frame_wrap) begin
                r_h_snap <= bus.horas;
                r_m_snap <= bus.minutos;
            end else begin
                r_h_snap <= r_h_snap;
                r_m_snap <= r_m_snap;
            end
        end
    end

    // Output registers: anode, segments and colon switch on the same edge.
    always_ff @(posedge clock) begin
        if (reset || r_start) begin
            r_anodos    <= 4'b1111;
            r_segmentos <= SEG_BLANK;
            r_punto     <= 1'b1;
        end else begin
            r_anodos    <= w_ano_next;
            r_segmentos <= w_seg_next;
            r_punto     <= (r_idx == 2'd2) ? ~r_colon : 1'b1;
        end
    end

    assign bus.anodos    = r_anodos;
    assign bus.segmentos = r_segmentos;
    assign bus.punto     = r_punto;

endmodule
